// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Issue / CDB writeback / operand query / register-file write
//               bundle between the core pipeline and the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if #(
  parameter int TAG_W = 3
);
  // Allocation
  logic             issue_valid;
  logic             issue_has_dest;
  logic [4:0]       issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic             full;
  logic             empty;
  // Common data bus
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_value;
  // Operand forwarding lookup
  logic [TAG_W-1:0] query_tag;
  logic             query_ready;
  logic [31:0]      query_value;
  // Register-file write port
  logic             to_rf_valid;
  logic [4:0]       to_rf_rd;
  logic [31:0]      to_rf_wdata;

  // Pipeline side: drives requests, observes buffer state
  modport master (
    output issue_valid, issue_has_dest, issue_rd,
    output wb_valid, wb_tag, wb_value,
    output query_tag,
    input  issue_tag, full, empty,
    input  query_ready, query_value,
    input  to_rf_valid, to_rf_rd, to_rf_wdata
  );

  // Reorder buffer side
  modport slave (
    input  issue_valid, issue_has_dest, issue_rd,
    input  wb_valid, wb_tag, wb_value,
    input  query_tag,
    output issue_tag, full, empty,
    output query_ready, query_value,
    output to_rf_valid, to_rf_rd, to_rf_wdata
  );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement buffer. Allocates a tag per issued
//               instruction, captures CDB results and retires one entry per
//               cycle in program order to the register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  wire logic        clk_in,
  input  wire logic        rst_in,
  input  wire logic        rdy_in,
  input  wire logic        flush_in,
  reorder_buffer_if.slave  rob_if
);

  localparam int              CNT_W     = TAG_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Per-entry storage
  logic [DEPTH-1:0] busy_q,     busy_d;
  logic [DEPTH-1:0] ready_q,    ready_d;
  logic [DEPTH-1:0] has_dest_q, has_dest_d;
  logic [4:0]       rd_q    [DEPTH];
  logic [4:0]       rd_d    [DEPTH];
  logic [31:0]      value_q [DEPTH];
  logic [31:0]      value_d [DEPTH];

  // Pointers and occupancy; count disambiguates full from empty
  logic [TAG_W-1:0] head_q,  head_d;
  logic [TAG_W-1:0] tail_q,  tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Registered register-file write port
  logic             to_rf_valid_q, to_rf_valid_d;
  logic [4:0]       to_rf_rd_q,    to_rf_rd_d;
  logic [31:0]      to_rf_wdata_q, to_rf_wdata_d;

  logic full, empty, issue_fire, commit_fire;

  // Full is taken from the registered count, so a slot freed by this cycle's
  // commit cannot be reallocated until the next cycle.
  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign issue_fire  = rob_if.issue_valid && !full && !flush_in;
  assign commit_fire = busy_q[head_q] && ready_q[head_q];

  assign rob_if.issue_tag   = tail_q;
  assign rob_if.full        = full;
  assign rob_if.empty       = empty;
  // Lookup reflects registered state only; a same-cycle CDB result is not bypassed
  assign rob_if.query_ready = busy_q[rob_if.query_tag] && ready_q[rob_if.query_tag];
  assign rob_if.query_value = value_q[rob_if.query_tag];
  assign rob_if.to_rf_valid = to_rf_valid_q;
  assign rob_if.to_rf_rd    = to_rf_rd_q;
  assign rob_if.to_rf_wdata = to_rf_wdata_q;

  // Next-state: flush dominates; otherwise writeback, then commit, then issue
  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    has_dest_d    = has_dest_q;
    rd_d          = rd_q;
    value_d       = value_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    to_rf_valid_d = 1'b0;
    to_rf_rd_d    = to_rf_rd_q;
    to_rf_wdata_d = to_rf_wdata_q;

    if (flush_in) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (rob_if.wb_valid && busy_q[rob_if.wb_tag]) begin
        ready_d[rob_if.wb_tag] = 1'b1;
        value_d[rob_if.wb_tag] = rob_if.wb_value;
      end
      // Commit clears ready after the writeback so a late CDB hit cannot
      // resurrect the retiring entry.
      if (commit_fire) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
        to_rf_valid_d   = has_dest_q[head_q] && (rd_q[head_q] != 5'd0);
        to_rf_rd_d      = rd_q[head_q];
        to_rf_wdata_d   = value_q[head_q];
      end
      // Tail never equals a busy head while not full, so no slot conflict
      if (issue_fire) begin
        busy_d[tail_q]     = 1'b1;
        ready_d[tail_q]    = 1'b0;
        has_dest_d[tail_q] = rob_if.issue_has_dest;
        rd_d[tail_q]       = rob_if.issue_rd;
        tail_d             = tail_q + TAG_W'(1);
      end
      count_d = count_q + CNT_W'(issue_fire) - CNT_W'(commit_fire);
    end
  end

  // State register: async reset, frozen while rdy_in is low
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_d_reset_loop: for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      busy_q        <= '0;
      ready_q       <= '0;
      has_dest_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      to_rf_valid_q <= 1'b0;
      to_rf_rd_q    <= '0;
      to_rf_wdata_q <= '0;
    end else if (rdy_in) begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      has_dest_q    <= has_dest_d;
      rd_q          <= rd_d;
      value_q       <= value_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      to_rf_valid_q <= to_rf_valid_d;
      to_rf_rd_q    <= to_rf_rd_d;
      to_rf_wdata_q <= to_rf_wdata_d;
    end else begin
      to_rf_valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer: a cycle-by-cycle
//               vector table plus directed full/wrap, flush, stall and
//               asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  logic clk_in  = 1'b0;
  logic rst_in  = 1'b1;
  logic rdy_in  = 1'b1;
  logic flush_in = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer_if #(.TAG_W(3)) rob_if ();

  reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .flush_in(flush_in),
    .rob_if  (rob_if)
  );

  always #5 clk_in = ~clk_in;

  // One cycle of stimulus and the outputs expected while it is applied
  typedef struct {
    logic        iv;
    logic        hd;
    logic [4:0]  rd;
    logic        wv;
    logic [2:0]  wt;
    logic [31:0] wval;
    logic        fl;
    logic [2:0]  qt;
    logic        cq;
    logic [2:0]  e_tag;
    logic        e_full;
    logic        e_empty;
    logic        e_rfv;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_qr;
    logic [31:0] e_qv;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic hd, input logic [4:0] rd,
                       input logic wv, input logic [2:0] wt, input logic [31:0] wval,
                       input logic fl, input logic [2:0] qt);
    rob_if.issue_valid    = iv;
    rob_if.issue_has_dest = hd;
    rob_if.issue_rd       = rd;
    rob_if.wb_valid       = wv;
    rob_if.wb_tag         = wt;
    rob_if.wb_value       = wval;
    flush_in              = fl;
    rob_if.query_tag      = qt;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    //            iv    hd    rd     wv    wt    wval          fl    qt    cq    tag   full  empty rfv   rd     wdata         qr    qv
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 5'd6,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 5'd7,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  1'b1, 3'd1, 32'hAAAA0001, 1'b0, 3'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  1'b1, 3'd0, 32'h12345678, 1'b0, 3'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 32'hAAAA0001};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 32'h12345678};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 5'd5,  32'h12345678, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 5'd6,  32'hAAAA0001, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 5'd9,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  1'b1, 3'd2, 32'h22,       1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  1'b1, 3'd3, 32'h33,       1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  1'b1, 3'd4, 32'h44,       1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 5'd7,  32'h22,       1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 3'd3, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 5'd10, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[16] = '{1'b1, 1'b1, 5'd11, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b1, 5'd12, 1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[18] = '{1'b1, 1'b1, 5'd13, 1'b1, 3'd5, 32'h55,       1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[19] = '{1'b1, 1'b1, 5'd14, 1'b1, 3'd6, 32'h66,       1'b1, 3'd5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 32'h55};
    vecs[20] = '{1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[21] = '{1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};

    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    repeat (2) tick();
    rst_in = 1'b0;

    // Reset state
    @(negedge clk_in);
    chk("rst empty",    32'(rob_if.empty),       32'd1);
    chk("rst full",     32'(rob_if.full),        32'd0);
    chk("rst tag",      32'(rob_if.issue_tag),   32'd0);
    chk("rst rf_valid", 32'(rob_if.to_rf_valid), 32'd0);
    chk("rst rf_rd",    32'(rob_if.to_rf_rd),    32'd0);
    chk("rst rf_wdata", rob_if.to_rf_wdata,      32'd0);
    tick();

    // Issue, out-of-order writeback, in-order commit, rd=0/no-dest, flush
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].hd, vecs[i].rd, vecs[i].wv, vecs[i].wt,
            vecs[i].wval, vecs[i].fl, vecs[i].qt);
      @(negedge clk_in);
      chk($sformatf("v%0d tag", i),      32'(rob_if.issue_tag),   32'(vecs[i].e_tag));
      chk($sformatf("v%0d full", i),     32'(rob_if.full),        32'(vecs[i].e_full));
      chk($sformatf("v%0d empty", i),    32'(rob_if.empty),       32'(vecs[i].e_empty));
      chk($sformatf("v%0d rf_valid", i), 32'(rob_if.to_rf_valid), 32'(vecs[i].e_rfv));
      if (vecs[i].e_rfv) begin
        chk($sformatf("v%0d rf_rd", i),    32'(rob_if.to_rf_rd), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d rf_wdata", i), rob_if.to_rf_wdata,   vecs[i].e_wd);
      end
      if (vecs[i].cq) begin
        chk($sformatf("v%0d q_ready", i), 32'(rob_if.query_ready), 32'(vecs[i].e_qr));
        if (vecs[i].e_qr)
          chk($sformatf("v%0d q_value", i), rob_if.query_value, vecs[i].e_qv);
      end
      tick();
    end

    // Fill to full, reject a ninth issue, then wrap into the freed slot
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      @(negedge clk_in);
      chk($sformatf("fill%0d tag", i),  32'(rob_if.issue_tag), 32'(i));
      chk($sformatf("fill%0d full", i), 32'(rob_if.full),      32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 5'd20, 1'b1, 3'd0, 32'hC0DE0000, 1'b0, 3'd0);
    @(negedge clk_in);
    chk("full A full", 32'(rob_if.full),      32'd1);
    chk("full A tag",  32'(rob_if.issue_tag), 32'd0);
    tick();
    drive(1'b1, 1'b1, 5'd20, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    @(negedge clk_in);
    chk("full B full", 32'(rob_if.full),        32'd1);
    chk("full B tag",  32'(rob_if.issue_tag),   32'd0);
    chk("full B rfv",  32'(rob_if.to_rf_valid), 32'd0);
    tick();
    @(negedge clk_in);
    chk("full C full",  32'(rob_if.full),        32'd0);
    chk("full C tag",   32'(rob_if.issue_tag),   32'd0);
    chk("full C rfv",   32'(rob_if.to_rf_valid), 32'd1);
    chk("full C rd",    32'(rob_if.to_rf_rd),    32'd1);
    chk("full C wdata", rob_if.to_rf_wdata,      32'hC0DE0000);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    @(negedge clk_in);
    chk("wrap D full", 32'(rob_if.full),        32'd1);
    chk("wrap D tag",  32'(rob_if.issue_tag),   32'd1);
    chk("wrap D rfv",  32'(rob_if.to_rf_valid), 32'd0);
    tick();

    // Flush a full buffer back to empty
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    @(negedge clk_in);
    chk("flush2 empty", 32'(rob_if.empty),     32'd1);
    chk("flush2 tag",   32'(rob_if.issue_tag), 32'd0);
    tick();

    // Stall: ready head must not retire while rdy_in is low
    drive(1'b1, 1'b1, 5'd3, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'h77, 1'b0, 3'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk($sformatf("stall%0d rfv", i),   32'(rob_if.to_rf_valid), 32'd0);
      chk($sformatf("stall%0d empty", i), 32'(rob_if.empty),       32'd0);
      chk($sformatf("stall%0d qr", i),    32'(rob_if.query_ready), 32'd1);
      tick();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("resume rfv", 32'(rob_if.to_rf_valid), 32'd0);
    tick();
    @(negedge clk_in);
    chk("resume2 rfv",   32'(rob_if.to_rf_valid), 32'd1);
    chk("resume2 rd",    32'(rob_if.to_rf_rd),    32'd3);
    chk("resume2 wdata", rob_if.to_rf_wdata,      32'h77);
    chk("resume2 empty", 32'(rob_if.empty),       32'd1);

    // Asynchronous reset while the write strobe is high, between clock edges
    #2 rst_in = 1'b1;
    #1;
    chk("arst rfv",   32'(rob_if.to_rf_valid), 32'd0);
    chk("arst rd",    32'(rob_if.to_rf_rd),    32'd0);
    chk("arst empty", 32'(rob_if.empty),       32'd1);
    chk("arst tag",   32'(rob_if.issue_tag),   32'd0);
    tick();
    rst_in = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the out-of-order RISC-V core.
- Allocates a tag per issued instruction and captures results from the common data bus (CDB).
- Retires entries strictly in program order, emitting one register-file write per cycle to the register file's ROB write port (valid / rd / wdata).
- Provides a combinational tag query port so reservation stations can forward completed-but-uncommitted values.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- TAG_W, 3, tag width; must equal log2(DEPTH).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global enable; all state holds while low.
- flush_in  input  1  synchronous squash of all entries (mispredict).
- issue_valid  input  1  allocate request.
- issue_has_dest  input  1  instruction writes rd.
- issue_rd  input  5  destination register.
- issue_tag  output  TAG_W  tag granted this cycle (= tail); combinational.
- full  output  1  count == DEPTH; combinational.
- empty  output  1  count == 0; combinational.
- wb_valid  input  1  CDB result valid.
- wb_tag  input  TAG_W  CDB result tag.
- wb_value  input  32  CDB result value.
- query_tag  input  TAG_W  operand lookup tag.
- query_ready  output  1  entry busy and ready; combinational.
- query_value  output  32  value of the queried entry; combinational.
- to_rf_valid  output  1  register-file write strobe; registered.
- to_rf_rd  output  5  register-file write index; registered.
- to_rf_wdata  output  32  register-file write data; registered.

Behaviour:
Storage:
- Each entry holds busy, ready, has_dest, rd[4:0] and value[31:0].
- head, tail: TAG_W-bit pointers that wrap modulo DEPTH.
- count: (TAG_W+1) bits.

Reset (asynchronous):
- All busy/ready bits, head, tail and count are 0.
- to_rf_valid = 0, to_rf_rd = 0, to_rf_wdata = 0.

rdy_in low:
- No state changes.
- to_rf_valid forced to 0 on the next clock edge.

Issue:
- Accepted when issue_valid && !full && !flush_in.
- entry[tail] gets busy=1, ready=0, has_dest=issue_has_dest, rd=issue_rd.
- tail increments.
- full is sampled from count before any same-cycle commit, so there is no issue into a slot freed in the same cycle.

Writeback:
- When wb_valid and entry[wb_tag].busy: set ready=1 and value=wb_value.
- A writeback to a non-busy entry is ignored.

Commit:
- Evaluated on the registered state only: fires when entry[head].busy && entry[head].ready.
- head increments and the entry's busy and ready bits clear.
- to_rf_valid = has_dest && (rd != 0), with to_rf_rd = rd and to_rf_wdata = value. These appear one cycle after the commit decision, as a single-cycle pulse.
- If there is no commit, to_rf_valid = 0 and to_rf_rd / to_rf_wdata hold their previous values.
- Maximum one commit per cycle.
- A writeback to the head entry commits no earlier than the following cycle (one cycle minimum from CDB to commit decision).

Count update:
- count += issue_accepted − committed; simultaneous issue and commit leaves count unchanged.

Flush:
- Clears all busy/ready bits and sets head = tail = count = 0.
- to_rf_valid = 0.
- Dominates issue, writeback and commit in the same cycle.

Query:
- query_ready = busy && ready of entry[query_tag]; query_value = entry[query_tag].value.
- Does not bypass a same-cycle wb_* (no CDB bypass).

Wrap-around:
- Pointers roll from DEPTH−1 to 0 with no bubble; count fully disambiguates full from empty.

Test Plan:
1. Reset, then issue 3 entries (rd=5,6,7, has_dest=1) -> tags 0,1,2; count=3; empty=0; no to_rf_valid.
2. Writeback tag 1 value 0xAAAA0001, then tag 0 value 0x12345678 -> commits in order. Cycle after tag-0 writeback: commit decision; next cycle: to_rf rd=5 wdata 0x12345678. Following cycle: rd=6 wdata 0xAAAA0001.
3. Issue 8 entries -> full=1; a 9th issue_valid is ignored (issue_tag stays 0 and tail holds). Commit one entry while issue_valid is held -> the issue is accepted the cycle after full drops, with granted tag 0 (wrap).
4. Commit an entry with rd=0 and an entry with has_dest=0 -> head advances both times; to_rf_valid stays 0.
5. flush_in asserted in the same cycle as issue_valid and wb_valid with 4 entries live -> count=0, empty=1, issue_tag=0; no to_rf_valid follows.
6. Assert rst_in mid-commit (to_rf_valid=1) -> to_rf_valid drops immediately without a clock edge; all pointers are 0. Separately, hold rdy_in low for 3 cycles with a ready head entry -> no commit until rdy_in returns high.
